// File: rtl/cpu_writeback_arbiter.sv
// Writeback port arbiter: picks one result producer per cycle and registers
// {rd, value} onto the 39-bit toggle-strobe writeback bus.
module cpu_writeback_arbiter #(
    parameter int unsigned NUM_SOURCES    = 3,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NUM_SOURCES-1:0]    i_req,
    input  logic [6*NUM_SOURCES-1:0]  i_rd,
    input  logic [32*NUM_SOURCES-1:0] i_value,
    input  logic                      i_hold,
    output logic [NUM_SOURCES-1:0]    o_ack,
    output logic [38:0]               o_data,
    output logic [31:0]               o_conflicts,
    output logic [31:0]               o_writes
);

    localparam int unsigned PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [PTR_W-1:0]       r_ptr;
    logic [38:0]            r_data;
    logic [31:0]            r_conflicts;
    logic [31:0]            r_writes;

    logic [NUM_SOURCES-1:0] w_ack;
    logic [PTR_W-1:0]       w_gidx;
    logic                   w_found;
    logic [31:0]            w_scan;
    logic [5:0]             w_rd;
    logic [31:0]            w_val;
    logic                   w_conflict;

    // Scan order starts just after the last winner (round-robin) or at 0 (fixed).
    always_comb begin
        w_ack   = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_scan  = '0;
        if (!i_reset && !i_hold) begin
            for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
                if (FIXED_PRIORITY != 0)
                    w_scan = i;
                else
                    w_scan = (32'(r_ptr) + 32'd1 + i) % NUM_SOURCES;
                if (!w_found && i_req[w_scan[PTR_W-1:0]]) begin
                    w_found = 1'b1;
                    w_gidx  = w_scan[PTR_W-1:0];
                end
            end
            if (w_found)
                w_ack[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_rd  = '0;
        w_val = '0;
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            if (w_ack[k]) begin
                w_rd  = i_rd[k*6 +: 6];
                w_val = i_value[k*32 +: 32];
            end
        end
    end

    assign w_conflict = !i_hold && ($countones(i_req) >= 2);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data      <= '0;
            r_conflicts <= '0;
            r_writes    <= '0;
            r_ptr       <= PTR_W'(NUM_SOURCES - 1);
        end else begin
            if (w_found) begin
                r_data   <= {~r_data[38], w_rd, w_val};
                r_writes <= r_writes + 32'd1;
                if (FIXED_PRIORITY == 0)
                    r_ptr <= w_gidx;
            end
            if (w_conflict && (r_conflicts != '1))
                r_conflicts <= r_conflicts + 32'd1;
        end
    end

    assign o_ack       = w_ack;
    assign o_data      = r_data;
    assign o_conflicts = r_conflicts;
    assign o_writes    = r_writes;

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
// Directed bench for cpu_writeback_arbiter: one round-robin and one
// fixed-priority instance driven from the same stimulus.
module tb_cpu_writeback_arbiter;

    localparam int unsigned N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [6*N-1:0]  rd;
    logic [32*N-1:0] val;
    logic            hold;

    logic [N-1:0]    ack_rr, ack_fx;
    logic [38:0]     data_rr, data_fx;
    logic [31:0]     conf_rr, conf_fx, wr_rr, wr_fx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_writeback_arbiter #(.NUM_SOURCES(N), .FIXED_PRIORITY(0)) u_rr (
        .i_clock(clk), .i_reset(rst), .i_req(req), .i_rd(rd), .i_value(val),
        .i_hold(hold), .o_ack(ack_rr), .o_data(data_rr),
        .o_conflicts(conf_rr), .o_writes(wr_rr)
    );

    cpu_writeback_arbiter #(.NUM_SOURCES(N), .FIXED_PRIORITY(1)) u_fx (
        .i_clock(clk), .i_reset(rst), .i_req(req), .i_rd(rd), .i_value(val),
        .i_hold(hold), .o_ack(ack_fx), .o_data(data_fx),
        .o_conflicts(conf_fx), .o_writes(wr_fx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int unsigned k, input logic [5:0] r, input logic [31:0] v);
        rd[k*6 +: 6]   = r;
        val[k*32 +: 32] = v;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        hold = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b010; hold = 1'b0; rd = '0; val = '0;
        #1;
        checks++; if (ack_rr !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack_rr); end
        tick(); tick();
        checks++; if (data_rr !== 39'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_rr); end
        checks++; if (conf_rr !== 32'd0) begin errors++; $display("FAIL reset_conflicts: got %0d expected 0", conf_rr); end
        checks++; if (wr_rr !== 32'd0) begin errors++; $display("FAIL reset_writes: got %0d expected 0", wr_rr); end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single();
        set_src(1, 6'd5, 32'hDEADBEEF);
        req = 3'b010;
        #1;
        checks++; if (ack_rr !== 3'b010) begin errors++; $display("FAIL single_ack: got %b expected 010", ack_rr); end
        tick();
        req = '0;
        #1;
        checks++; if (data_rr !== {1'b1, 6'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL single_data: got %h expected %h", data_rr, {1'b1, 6'd5, 32'hDEADBEEF}); end
        checks++; if (wr_rr !== 32'd1) begin errors++; $display("FAIL single_writes: got %0d expected 1", wr_rr); end
        checks++; if (ack_rr !== 3'b000) begin errors++; $display("FAIL single_idle_ack: got %b expected 000", ack_rr); end
    endtask

    task automatic test_round_robin();
        logic [38:0] exp;
        logic [N-1:0] exp_ack;
        logic [5:0]  exp_rd [N];
        logic [31:0] exp_val [N];
        do_reset();
        for (int unsigned k = 0; k < N; k++) begin
            exp_rd[k]  = 6'(10 + k);
            exp_val[k] = 32'hA000_0000 + k;
            set_src(k, exp_rd[k], exp_val[k]);
        end
        req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_ack = N'(1 << (c % 3));
            checks++; if (ack_rr !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", c, ack_rr, exp_ack); end
            checks++; if (ack_fx !== 3'b001) begin errors++; $display("FAIL fx_all_ack[%0d]: got %b expected 001", c, ack_fx); end
            tick();
            exp = {1'((c + 1) % 2), exp_rd[c % 3], exp_val[c % 3]};
            checks++; if (data_rr !== exp) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", c, data_rr, exp); end
        end
        req = '0;
        checks++; if (data_rr[38] !== 1'b0) begin errors++; $display("FAIL rr_strobe_end: got %b expected 0", data_rr[38]); end
        checks++; if (conf_rr !== 32'd6) begin errors++; $display("FAIL rr_conflicts: got %0d expected 6", conf_rr); end
        checks++; if (wr_rr !== 32'd6) begin errors++; $display("FAIL rr_writes: got %0d expected 6", wr_rr); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        set_src(0, 6'd1, 32'h0000_1111);
        set_src(2, 6'd3, 32'h0000_3333);
        req = 3'b101;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (ack_fx !== 3'b001) begin errors++; $display("FAIL fx_ack[%0d]: got %b expected 001", c, ack_fx); end
            tick();
        end
        req = 3'b100;
        #1;
        checks++; if (ack_fx !== 3'b100) begin errors++; $display("FAIL fx_ack_src2: got %b expected 100", ack_fx); end
        tick();
        req = '0;
        checks++; if (data_fx !== {1'b1, 6'd3, 32'h0000_3333}) begin errors++; $display("FAIL fx_data: got %h expected %h", data_fx, {1'b1, 6'd3, 32'h0000_3333}); end
        checks++; if (wr_fx !== 32'd5) begin errors++; $display("FAIL fx_writes: got %0d expected 5", wr_fx); end
        checks++; if (conf_fx !== 32'd4) begin errors++; $display("FAIL fx_conflicts: got %0d expected 4", conf_fx); end
    endtask

    task automatic test_hold();
        do_reset();
        set_src(0, 6'd7, 32'h7777_0000);
        set_src(2, 6'd9, 32'h9999_0000);
        req = 3'b001;
        tick();
        req  = 3'b101;
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ack_rr !== 3'b000) begin errors++; $display("FAIL hold_ack[%0d]: got %b expected 000", c, ack_rr); end
            tick();
            checks++; if (data_rr !== {1'b1, 6'd7, 32'h7777_0000}) begin errors++; $display("FAIL hold_data[%0d]: got %h expected %h", c, data_rr, {1'b1, 6'd7, 32'h7777_0000}); end
            checks++; if (wr_rr !== 32'd1 || conf_rr !== 32'd0) begin errors++; $display("FAIL hold_counters[%0d]: got writes %0d conflicts %0d expected 1 0", c, wr_rr, conf_rr); end
        end
        hold = 1'b0;
        #1;
        checks++; if (ack_rr !== 3'b100) begin errors++; $display("FAIL hold_release_ack: got %b expected 100", ack_rr); end
        tick();
        req = '0;
        checks++; if (data_rr !== {1'b0, 6'd9, 32'h9999_0000}) begin errors++; $display("FAIL hold_release_data: got %h expected %h", data_rr, {1'b0, 6'd9, 32'h9999_0000}); end
        checks++; if (wr_rr !== 32'd2 || conf_rr !== 32'd1) begin errors++; $display("FAIL hold_release_counters: got writes %0d conflicts %0d expected 2 1", wr_rr, conf_rr); end
    endtask

    task automatic test_withdraw();
        do_reset();
        set_src(1, 6'd20, 32'h2020_0001);
        req = 3'b010;
        tick();
        set_src(0, 6'd30, 32'h3030_3030);
        set_src(1, 6'd21, 32'h2020_0002);
        req  = 3'b011;
        hold = 1'b1;
        #1;
        checks++; if (ack_rr !== 3'b000) begin errors++; $display("FAIL withdraw_held_ack: got %b expected 000", ack_rr); end
        tick();
        hold = 1'b0;
        req  = 3'b010;
        #1;
        checks++; if (ack_rr !== 3'b010) begin errors++; $display("FAIL withdraw_ack: got %b expected 010", ack_rr); end
        tick();
        req = '0;
        checks++; if (data_rr !== {1'b0, 6'd21, 32'h2020_0002}) begin errors++; $display("FAIL withdraw_data: got %h expected %h", data_rr, {1'b0, 6'd21, 32'h2020_0002}); end
        checks++; if (wr_rr !== 32'd2) begin errors++; $display("FAIL withdraw_writes: got %0d expected 2", wr_rr); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_src(0, 6'd0, 32'h0BAD_F00D);
        set_src(1, 6'd11, 32'h1111_ABCD);
        req = 3'b010;
        tick();
        rst = 1'b1;
        req = 3'b011;
        #1;
        checks++; if (ack_rr !== 3'b000) begin errors++; $display("FAIL rstmid_ack: got %b expected 000", ack_rr); end
        tick();
        rst = 1'b0;
        checks++; if (data_rr !== 39'd0 || wr_rr !== 32'd0) begin errors++; $display("FAIL rstmid_state: got data %h writes %0d expected 0 0", data_rr, wr_rr); end
        #1;
        checks++; if (ack_rr !== 3'b001) begin errors++; $display("FAIL rstmid_first_ack: got %b expected 001", ack_rr); end
        tick();
        req = '0;
        checks++; if (data_rr !== {1'b1, 6'd0, 32'h0BAD_F00D}) begin errors++; $display("FAIL rstmid_data: got %h expected %h", data_rr, {1'b1, 6'd0, 32'h0BAD_F00D}); end
    endtask

    initial begin
        rst = 1'b1; req = '0; rd = '0; val = '0; hold = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_hold();
        test_withdraw();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
